// File: rtl/trace_chk_pkg.sv
// rtl/trace_chk_pkg.sv - shared types, constants and ROM initialiser for the trace checker
package trace_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       care_rval;
        logic [7:0] exp_instr;
        logic [7:0] exp_rval;
    } rom_entry_t;

    localparam logic [7:0] NOP_OP_DEFAULT = 8'h00;

    // Expected retirement trace; entry 7 writes a don't-care result value.
    function automatic rom_entry_t rom_init(input logic [7:0] idx);
        rom_entry_t e;
        e.care_rval = (idx != 8'd7);
        e.exp_instr = 8'h10 + idx;
        e.exp_rval  = 8'h80 + {idx[6:0], 1'b0};
        return e;
    endfunction

endpackage

// File: rtl/trace_chk_rom.sv
// rtl/trace_chk_rom.sv - combinational expected-trace ROM, contents from trace_chk_pkg::rom_init
module trace_chk_rom
    import trace_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] addr,
    output logic [16:0]      data
);

    rom_entry_t mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_init
        assign mem[i] = rom_init(8'(i));
    end

    assign data = mem[addr];

endmodule

// File: rtl/pipeline_trace_checker.sv
// rtl/pipeline_trace_checker.sv - in-order retirement trace checker; optional watchdog via TRACE_CHK_TIMEOUT_EN
module pipeline_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         IDX_W   = 4,
    parameter int         CNT_W   = 8,
    parameter logic [7:0] NOP_OP  = NOP_OP_DEFAULT,
    parameter int         TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       instr,
    input  logic [7:0]       rVal,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             timeout
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ferr_q, ferr_d;
    logic             tout_q, tout_d;

    logic [16:0] rom_data;
    rom_entry_t  exp_e;
    logic        beat, mismatch, last, active, idle_hit;

    trace_chk_rom #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rom (
        .addr (idx_q),
        .data (rom_data)
    );

    assign exp_e    = rom_entry_t'(rom_data);
    assign active   = (state_q == SYNC) || (state_q == CHECK);
    // Leading NOPs are pipeline fill; once locked on, every beat is a trace entry.
    assign beat     = in_valid && (((state_q == SYNC) && (instr != NOP_OP)) || (state_q == CHECK));
    assign mismatch = (instr != exp_e.exp_instr) || (exp_e.care_rval && (rVal != exp_e.exp_rval));
    assign last     = (idx_q == IDX_W'(DEPTH - 1));

`ifdef TRACE_CHK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;

    assign idle_hit = active && !in_valid && (idle_q == IW'(TIMEOUT - 1));

    always_comb begin
        idle_d = '0;
        if (active && !in_valid && !idle_hit) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;
    assign idle_hit       = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ferr_d  = ferr_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SYNC;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ferr_d  = '0;
                    tout_d  = 1'b0;
                end
            end
            SYNC, CHECK: begin
                if (beat) begin
                    if (mismatch) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == '0) ferr_d = idx_q;
                    end
                    if ((state_q == CHECK) && last) begin
                        state_d = DONE;
                    end else begin
                        state_d = CHECK;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (idle_hit) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ferr_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
            tout_q  <= tout_d;
        end
    end

    assign busy           = active;
    assign done           = (state_q == DONE);
    assign pass           = done && (cnt_q == '0) && !tout_q;
    assign mismatch_count = cnt_q;
    assign first_err_idx  = ferr_q;
    assign timeout        = tout_q;

endmodule

// File: tb/tb_pipeline_trace_checker.sv
// tb/tb_pipeline_trace_checker.sv - scoreboard bench for pipeline_trace_checker (default and CNT_W=2 instances)
module tb_pipeline_trace_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [7:0] rVal = 8'h00;

    logic       busy, done, pass, timeout;
    logic [7:0] cnt;
    logic [3:0] ferr;
    logic       busy2, done2, pass2, tout2;
    logic [1:0] cnt2;
    logic [3:0] ferr2;

    pipeline_trace_checker u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .instr(instr), .rVal(rVal), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(cnt), .first_err_idx(ferr), .timeout(timeout)
    );

    pipeline_trace_checker #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .instr(instr), .rVal(rVal), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_count(cnt2), .first_err_idx(ferr2), .timeout(tout2)
    );

    always #5 clk = ~clk;

    logic [7:0] ei [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                            8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
    logic [7:0] er [16] = '{8'h80, 8'h82, 8'h84, 8'h86, 8'h88, 8'h8A, 8'h8C, 8'h8E,
                            8'h90, 8'h92, 8'h94, 8'h96, 8'h98, 8'h9A, 8'h9C, 8'h9E};

    typedef struct {
        logic       pass;
        logic       tout;
        logic [7:0] cnt;
        logic [3:0] ferr;
        logic [1:0] cnt2;
        logic [3:0] ferr2;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic done_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_d) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pass", 32'(pass), 32'(e.pass));
                check("timeout", 32'(timeout), 32'(e.tout));
                check("mismatch_count", 32'(cnt), 32'(e.cnt));
                if (e.cnt != 8'd0) check("first_err_idx", 32'(ferr), 32'(e.ferr));
                check("done_cnt2", 32'(done2), 32'd1);
                check("pass_cnt2", 32'(pass2), 32'(e.pass));
                check("mismatch_count_cnt2", 32'(cnt2), 32'(e.cnt2));
                if (e.cnt2 != 2'd0) check("first_err_idx_cnt2", 32'(ferr2), 32'(e.ferr2));
            end
        end
        done_d <= done;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] i, input logic [7:0] r);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = i;
        rVal     = r;
    endtask

    // mode 0: clean trace, 1: rVal bad at 4 and instr bad at 9, 2: every instr bad
    task automatic run(input int mode, input bit gaps);
        logic [7:0] i_b, r_b;
        for (int k = 0; k < 16; k++) begin
            i_b = ei[k];
            r_b = (k == 7) ? 8'h5A : er[k];
            if (mode == 1 && k == 4) r_b = er[k] ^ 8'h01;
            if (mode == 1 && k == 9) i_b = ei[k] ^ 8'h40;
            if (mode == 2) i_b = ~ei[k];
            beat(i_b, r_b);
            if (k == 15) check("done_early", 32'(done), 32'd0);
            if (gaps && k == 5) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("done_latency", 32'(done), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b1;

        beat(ei[0], er[0]);
        beat(ei[1], er[1]);
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ignores_valid_busy", 32'(busy), 32'd0);
        check("idle_ignores_valid_cnt", 32'(cnt), 32'd0);

        pulse_start();
        for (int k = 0; k < 5; k++) beat(8'hFF, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrun_cnt", 32'(cnt), 32'd5);
        check("midrun_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_cnt", 32'(cnt), 32'd0);
        check("abort_ferr", 32'(ferr), 32'd0);
        check("abort_timeout", 32'(timeout), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        sb.push_back('{1'b1, 1'b0, 8'd0, 4'd0, 2'd0, 4'd0});
        pulse_start();
        for (int k = 0; k < 3; k++) beat(8'h00, 8'h33);
        run(0, 1'b0);

        sb.push_back('{1'b0, 1'b0, 8'd2, 4'd4, 2'd2, 4'd4});
        pulse_start();
        run(1, 1'b0);

        sb.push_back('{1'b0, 1'b0, 8'd16, 4'd0, 2'd3, 4'd0});
        pulse_start();
        run(2, 1'b0);

        sb.push_back('{1'b1, 1'b0, 8'd0, 4'd0, 2'd0, 4'd0});
        pulse_start();
        run(0, 1'b1);
        beat(8'hEE, 8'hEE);
        beat(8'hEE, 8'hEE);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_holds", 32'(done), 32'd1);
        check("done_ignores_valid_cnt", 32'(cnt), 32'd0);

`ifdef TRACE_CHK_TIMEOUT_EN
        sb.push_back('{1'b0, 1'b1, 8'd0, 4'd0, 2'd0, 4'd0});
`endif
        pulse_start();
        for (int k = 0; k < 8; k++) beat(ei[k], (k == 7) ? 8'h5A : er[k]);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef TRACE_CHK_TIMEOUT_EN
        repeat (31) @(negedge clk);
        check("timeout_not_early", 32'(done), 32'd0);
        @(negedge clk);
        check("timeout_done", 32'(done), 32'd1);
`else
        repeat (40) @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_timeout", 32'(timeout), 32'd0);
        check("wait_done", 32'(done), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_trace_checker.md
Name: pipeline_trace_checker

Overview:
- Synthesizable consumer for the pipelined processor's retirement debug outputs (instr, rVal).
- Captures each retired pair and compares it in order against an expected-trace ROM.
- Reports pass/fail, a saturating mismatch count, and the index of the first error.
- Sits beside the processor in self-checking top levels, replacing manual waveform inspection.

Parameters:
- DEPTH, 16, number of expected trace entries checked per run (power of two, 2..256)
- IDX_W, 4, index width; equals log2(DEPTH)
- CNT_W, 8, mismatch counter width
- NOP_OP, 8'h00, instr encoding treated as pipeline-fill bubble while synchronising
- TIMEOUT, 32, idle-cycle limit; used only with the optional feature

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; arms a check run
- in_valid  in  1  retirement strobe; instr/rVal are meaningful this cycle
- instr  in  8  retired instruction byte from processor
- rVal  in  8  result value written back by that instruction
- busy  out  1  high in SYNC or CHECK
- done  out  1  high in DONE
- pass  out  1  high in DONE when mismatch_count==0 and no timeout
- mismatch_count  out  CNT_W  number of mismatching entries; saturates at all-ones
- first_err_idx  out  IDX_W  index of first mismatching entry; valid when mismatch_count!=0
- timeout  out  1  run ended by the idle watchdog

Behaviour:
- Reset is asynchronous and active-low. While reset==0:
  - state=IDLE, internal index=0.
  - All outputs 0; first_err_idx=0.
  - Deasserting reset mid-run abandons that run; no partial results are kept.
- States and transitions:
  - IDLE: start -> SYNC, clearing the counter, first_err_idx and timeout.
  - SYNC: discards in_valid beats with instr==NOP_OP. The first valid non-NOP beat is compared against entry 0; index becomes 1 and state -> CHECK.
  - CHECK: each in_valid beat is compared against entry[index] and index increments. The beat that compares entry DEPTH-1 moves state -> DONE on the same edge. NOPs are compared as ordinary entries here.
  - DONE: holds results. start -> SYNC with all results cleared.
- start is ignored in SYNC and CHECK. in_valid is ignored in IDLE and DONE.
- ROM entry format: {care_rval, exp_instr[7:0], exp_rval[7:0]}, 17 bits, read combinationally by index.
- Mismatch rule:
  - instr != exp_instr, or
  - care_rval==1 and rVal != exp_rval.
- Latency: results register on the clock edge that samples the beat. mismatch_count, first_err_idx, done and pass are visible one cycle after the beat.
- On a mismatch:
  - mismatch_count increments unless already all-ones, then holds.
  - first_err_idx is captured only when the count was 0.
- pass is combinational from state, count and timeout; it is 0 outside DONE.
- Back-to-back in_valid on every cycle is fully supported, with no stalls.
- Index wrap never occurs: DONE is entered before index would exceed DEPTH-1.

Optional Feature:
- Macro: TRACE_CHK_TIMEOUT_EN
- Defined:
  - An idle counter clears on in_valid and counts cycles in SYNC/CHECK without in_valid.
  - On reaching TIMEOUT: state -> DONE, timeout=1, pass=0.
  - A simultaneous in_valid on that cycle wins: it is processed normally and the counter clears.
- Undefined:
  - No counter is built; timeout is tied 0.
  - SYNC/CHECK wait indefinitely.

Decomposition:
- Shared package trace_chk_pkg holds:
  - the state enum (IDLE, SYNC, CHECK, DONE);
  - the ROM entry struct (care_rval, exp_instr, exp_rval);
  - the NOP_OP default constant.
- One sub-module, trace_chk_rom: a DEPTH-entry combinational ROM indexed by IDX_W bits, contents from an include/init file.
- The FSM, comparators and counters stay in the top module.

Test Plan:
- Reset low mid-CHECK after 5 beats, then high -> state IDLE, all outputs 0, next start restarts from entry 0.
- start, then 3 NOP beats, then 16 beats matching the ROM exactly -> NOPs skipped; done=1 and pass=1 one cycle after the 16th beat; mismatch_count=0.
- Matching stream with rVal wrong at index 4 (care_rval=1) and instr wrong at index 9 -> mismatch_count=2, first_err_idx=4, pass=0.
- Entry 7 has care_rval=0 and arbitrary rVal, instr correct -> no mismatch counted; pass=1.
- CNT_W=2, all 16 entries wrong -> mismatch_count saturates at 3, first_err_idx=0.
- With TRACE_CHK_TIMEOUT_EN and TIMEOUT=32: 8 good beats, then no in_valid -> 32 idle cycles later done=1, timeout=1, pass=0. Without the macro: busy stays 1, timeout=0.
